// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: one load/store in flight, RISC-V lane steering and load extension.
// Optional misalignment trap is enabled with `define DMEM_MISALIGN_TRAP_EN.
module dmem_access_ctrl #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [2:0]  FUNCT3_MEM,
    input  logic [31:0] ALU_OUT_MEM,
    input  logic [31:0] REG_DATA2_MEM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        STALL_MEM,
    output logic [31:0] LOAD_DATA_MEM,
    output logic        ACCESS_ERR_MEM
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(ACK_TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] addr_reg, wdata_reg, load_reg;
    logic [3:0]  be_reg;
    logic [2:0]  f3_reg;
    logic [1:0]  lo_reg;
    logic        we_reg, err_reg;

    logic        req_in, is_byte, is_half, latch, ack_take, fault;
    logic [31:0] wdata_in, ext_data;
    logic [3:0]  be_in;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [7:0]  lane [4];

    assign req_in = MemRead_MEM | MemWrite_MEM;

    // Stores only know SB/SH/word; loads also decode the unsigned byte/half codes.
    always_comb begin
        is_byte  = MemWrite_MEM ? (FUNCT3_MEM == 3'b000) : (FUNCT3_MEM[1:0] == 2'b00);
        is_half  = MemWrite_MEM ? (FUNCT3_MEM == 3'b001) : (FUNCT3_MEM[1:0] == 2'b01);
        wdata_in = REG_DATA2_MEM;
        be_in    = 4'b1111;
        if (MemWrite_MEM && is_byte) begin
            wdata_in = {4{REG_DATA2_MEM[7:0]}};
            be_in    = 4'b0001 << ALU_OUT_MEM[1:0];
        end else if (MemWrite_MEM && is_half) begin
            wdata_in = {2{REG_DATA2_MEM[15:0]}};
            be_in    = 4'b0011 << {ALU_OUT_MEM[1], 1'b0};
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = is_half ? ALU_OUT_MEM[0] : (!is_byte && (ALU_OUT_MEM[1:0] != 2'b00));
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_sel = lane[lo_reg];
        half_sel = lo_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_reg)
            3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ext_data = {24'd0, byte_sel};
            3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  ext_data = {16'd0, half_sel};
            default: ext_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        STALL_MEM  = 1'b0;
        latch      = 1'b0;
        ack_take   = 1'b0;
        fault      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_in) begin
                    STALL_MEM = 1'b1;
                    latch     = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        fault      = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = REQ;
                        cnt_next   = 4'd0;
                    end
`else
                    state_next = REQ;
                    cnt_next   = 4'd0;
`endif
                end
            end
            REQ: begin
                STALL_MEM = 1'b1;
                if (mem_ack) begin
                    ack_take   = 1'b1;
                    state_next = DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    fault      = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            load_reg  <= 32'd0;
            be_reg    <= 4'd0;
            f3_reg    <= 3'd0;
            lo_reg    <= 2'd0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= fault;
            if (latch) begin
                addr_reg  <= {ALU_OUT_MEM[31:2], 2'b00};
                wdata_reg <= wdata_in;
                be_reg    <= be_in;
                f3_reg    <= FUNCT3_MEM;
                lo_reg    <= ALU_OUT_MEM[1:0];
                we_reg    <= MemWrite_MEM;
            end
            // Abandoned accesses return zero so a stale value never masquerades as a result.
            if (fault) begin
                load_reg <= 32'd0;
            end else if (ack_take && !we_reg) begin
                load_reg <= ext_data;
            end
        end
    end

    assign mem_req        = (state_reg == REQ);
    assign mem_we         = (state_reg == REQ) && we_reg;
    assign mem_addr       = addr_reg;
    assign mem_wdata      = wdata_reg;
    assign mem_be         = be_reg;
    assign LOAD_DATA_MEM  = load_reg;
    assign ACCESS_ERR_MEM = err_reg;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized bench for dmem_access_ctrl against a transaction-level reference model.
module tb_dmem_access_ctrl;
    localparam int T = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead_MEM, MemWrite_MEM;
    logic [2:0]  FUNCT3_MEM;
    logic [31:0] ALU_OUT_MEM, REG_DATA2_MEM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        STALL_MEM;
    logic [31:0] LOAD_DATA_MEM;
    logic        ACCESS_ERR_MEM;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_txn = 0;
    logic [31:0] model_ld = 32'd0;

    dmem_access_ctrl #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .FUNCT3_MEM(FUNCT3_MEM), .ALU_OUT_MEM(ALU_OUT_MEM), .REG_DATA2_MEM(REG_DATA2_MEM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .STALL_MEM(STALL_MEM), .LOAD_DATA_MEM(LOAD_DATA_MEM), .ACCESS_ERR_MEM(ACCESS_ERR_MEM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (txn %0d)", tag, got, exp, n_txn);
        end
    endtask

    // One complete access; dly >= T means the memory never acknowledges.
    task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int dly, input logic [31:0] rd,
                          input bit spur);
        bit          is_b, is_h, mis, trap, tout;
        int          idx;
        logic [31:0] exp_wd, exp_ld, bv, hv;
        logic [3:0]  exp_be;

        if (st) begin
            is_b = (f3 == 3'd0);
            is_h = (f3 == 3'd1);
        end else begin
            is_b = (f3 == 3'd0) || (f3 == 3'd4);
            is_h = (f3 == 3'd1) || (f3 == 3'd5);
        end
        idx = int'(a % 4);
        mis = is_b ? 1'b0 : is_h ? (a % 2 == 1) : (idx != 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        trap = mis;
`else
        trap = 1'b0;
`endif
        tout = !trap && (dly >= T);
        if (!st)       exp_be = 4'hF;
        else if (is_b) exp_be = 4'(1 << idx);
        else if (is_h) exp_be = 4'(3 << (2 * (idx / 2)));
        else           exp_be = 4'hF;
        if (is_b)      exp_wd = {24'd0, d[7:0]} * 32'h01010101;
        else if (is_h) exp_wd = {16'd0, d[15:0]} * 32'h00010001;
        else           exp_wd = d;
        bv = (rd >> (8 * idx)) & 32'hFF;
        hv = (rd >> (16 * (idx / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    exp_ld = (bv >= 128) ? bv + 32'hFFFFFF00 : bv;
            3'd4:    exp_ld = bv;
            3'd1:    exp_ld = (hv >= 32768) ? hv + 32'hFFFF0000 : hv;
            3'd5:    exp_ld = hv;
            default: exp_ld = rd;
        endcase

        MemWrite_MEM  = st;
        MemRead_MEM   = !st || ($urandom % 2 == 1);
        FUNCT3_MEM    = f3;
        ALU_OUT_MEM   = a;
        REG_DATA2_MEM = d;
        #1;
        check("idle_stall", {31'd0, STALL_MEM}, 32'd1);
        check("idle_req", {31'd0, mem_req}, 32'd0);
        check("err_clear", {31'd0, ACCESS_ERR_MEM}, 32'd0);
        @(posedge clk); #1;
        if (!trap) begin
            for (int j = 0; j < T; j++) begin
                check("req", {31'd0, mem_req}, 32'd1);
                check("req_stall", {31'd0, STALL_MEM}, 32'd1);
                check("addr", mem_addr, {a[31:2], 2'b00});
                check("be", {28'd0, mem_be}, {28'd0, exp_be});
                check("we", {31'd0, mem_we}, {31'd0, st});
                if (st) check("wdata", mem_wdata, exp_wd);
                mem_ack   = (j == dly);
                mem_rdata = (j == dly) ? rd : $urandom;
                @(posedge clk); #1;
                mem_ack = 1'b0;
                if (j == dly) break;
            end
        end
        if (trap || tout) model_ld = 32'd0;
        else if (!st)     model_ld = exp_ld;
        mem_ack   = spur;
        mem_rdata = $urandom;
        #1;
        check("done_req", {31'd0, mem_req}, 32'd0);
        check("done_stall", {31'd0, STALL_MEM}, 32'd0);
        check("done_err", {31'd0, ACCESS_ERR_MEM}, {31'd0, trap | tout});
        check("load_data", LOAD_DATA_MEM, model_ld);
        $display("txn %0d st=%0d f3=%0d a=%h dly=%0d trap=%0d tout=%0d ld=%h",
                 n_txn, st, f3, a, dly, trap, tout, LOAD_DATA_MEM);
        n_txn++;
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0; FUNCT3_MEM = 3'd0;
        ALU_OUT_MEM = 32'd0; REG_DATA2_MEM = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_stall", {31'd0, STALL_MEM}, 32'd0);
        check("rst_err", {31'd0, ACCESS_ERR_MEM}, 32'd0);
        check("rst_be", {28'd0, mem_be}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_load", LOAD_DATA_MEM, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_txn(1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF, 1'b0);
        do_txn(1'b1, 3'b000, 32'h203, 32'hA5, 0, 32'h0, 1'b0);
        do_txn(1'b0, 3'b000, 32'h101, 32'h0, 0, 32'h00008000, 1'b1);
        do_txn(1'b0, 3'b100, 32'h101, 32'h0, 0, 32'h00008000, 1'b0);
        do_txn(1'b0, 3'b010, 32'h40, 32'h0, T, 32'h0, 1'b0);
        do_txn(1'b0, 3'b010, 32'h44, 32'h0, T - 1, 32'h12345678, 1'b0);
        do_txn(1'b1, 3'b001, 32'h302, 32'hBEEF, 2, 32'h0, 1'b1);
`ifdef DMEM_MISALIGN_TRAP_EN
        do_txn(1'b0, 3'b001, 32'h101, 32'h0, 0, 32'hFFFFFFFF, 1'b0);
`endif
        for (int i = 0; i < 40; i++) begin
            do_txn(1'(($urandom % 2)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   int'($urandom_range(0, T + 1)), $urandom, 1'(($urandom % 2)));
        end

        // Reset in the second REQ cycle; the late ack must be ignored.
        MemRead_MEM = 1'b1; MemWrite_MEM = 1'b0; FUNCT3_MEM = 3'b010; ALU_OUT_MEM = 32'h80;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        MemRead_MEM = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        #1;
        check("rstreq_req", {31'd0, mem_req}, 32'd0);
        check("rstreq_stall", {31'd0, STALL_MEM}, 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        model_ld = 32'd0;
        check("rstack_req", {31'd0, mem_req}, 32'd0);
        check("rstack_stall", {31'd0, STALL_MEM}, 32'd0);
        check("rstack_err", {31'd0, ACCESS_ERR_MEM}, 32'd0);
        check("rstack_load", LOAD_DATA_MEM, model_ld);
        do_txn(1'b0, 3'b101, 32'h106, 32'h0, 0, 32'h9ABC1234, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer between the MEM pipeline stage and a data memory with variable access latency. Accepts a load or store from MEM, issues one request/acknowledge transaction with RISC-V byte enables from funct3, and stalls the pipeline until it completes. Returns sign- or zero-extended load data to MEM/WB. Holds at most one access in flight.

## Interface
- `ACK_TIMEOUT`, default 15: cycles without acknowledge before the access is abandoned; 4-bit counter, legal range 1..15.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `MemRead_MEM` in 1: load request from the MEM stage.
- `MemWrite_MEM` in 1: store request from the MEM stage.
- `FUNCT3_MEM` in 3: access size and signedness.
- `ALU_OUT_MEM` in 32: byte address.
- `REG_DATA2_MEM` in 32: store data, low-aligned.
- `mem_req` out 1: request to the memory.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word address, `{ALU_OUT_MEM[31:2],2'b00}`.
- `mem_wdata` out 32: store data shifted into the addressed lanes.
- `mem_be` out 4: byte enables.
- `mem_ack` in 1: one-cycle completion pulse; read data is valid in the same cycle.
- `mem_rdata` in 32: read data.
- `STALL_MEM` out 1: freezes the pipeline stages from IF through MEM.
- `LOAD_DATA_MEM` out 32: extended load result.
- `ACCESS_ERR_MEM` out 1: one-cycle pulse when an access is misaligned or times out.

## Operation
- States: IDLE, REQ, DONE.
- IDLE:
  - If `MemRead_MEM|MemWrite_MEM`, latch the address, data, funct3 and the write flag. `MemWrite` wins if both are set.
  - Go to REG the same edge. `STALL_MEM` is combinationally high in IDLE whenever a request is present.
- REQ:
  - `mem_req`=1 and `STALL_MEM`=1; address, data and enables are held from the latched values.
  - On `mem_ack`: capture the extended `mem_rdata` (loads only) and go to DONE.
  - If `ACK_TIMEOUT` cycles pass in REQ without `mem_ack`: pulse `ACCESS_ERR_MEM`, set `LOAD_DATA_MEM`=0 and go to DONE.
- DONE:
  - `STALL_MEM`=0; the pipeline advances this cycle.
  - Requests present this cycle are ignored; they belong to the instruction just finishing.
  - Always returns to IDLE.
- Stores:
  - funct3 000 (SB): `mem_be`=`4'b0001<<a[1:0]`, byte replicated ×4.
  - funct3 001 (SH): `mem_be`=`4'b0011<<{a[1],1'b0}`, halfword replicated ×2.
  - funct3 010 and all other codes: `mem_be`=`4'b1111`.
- Loads:
  - `mem_be`=`4'b1111`.
  - Select byte/halfword by `a[1:0]`.
  - 000 LB: sign-extend. 100 LBU: zero-extend. 001 LH: sign-extend. 101 LHU: zero-extend. All other codes: LW.
- `LOAD_DATA_MEM` holds its value until the next load completes.
- Unexpected `mem_ack` in IDLE or DONE is ignored.
- Reset values: state IDLE; `mem_req`, `mem_we`, `STALL_MEM`, `ACCESS_ERR_MEM` = 0; `mem_be`=0; `mem_addr`, `mem_wdata`, `LOAD_DATA_MEM` = 0; timeout counter 0.
- Reset asserted in REQ: the request is dropped at that edge and an ack arriving afterwards is ignored.

## Timing
- Request seen at edge 0 → `mem_req` high from cycle 1 (REQ).
- `mem_ack` in cycle k → DONE in cycle k+1 with `LOAD_DATA_MEM` valid → IDLE in cycle k+2.
- Minimum access (ack in first REQ cycle): 3 cycles, of which `STALL_MEM` is high for 2.
- Back-to-back accesses: a new request can be accepted in the IDLE cycle after DONE.
- `mem_req` deasserts in the cycle after `mem_ack`; exactly one ack is consumed per request.
- Timeout: the counter starts at 0 on REQ entry and increments every REQ cycle. On reaching `ACK_TIMEOUT`-1 with no ack, the next edge goes to DONE.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A misaligned request (half with `a[0]`=1, word with `a[1:0]`≠0) never enters REQ.
  - IDLE→DONE directly, `ACCESS_ERR_MEM` pulses in the DONE cycle, `mem_req` stays 0, load result 0.
- Not defined:
  - No misalignment check; low address bits are ignored for lane selection beyond the rules above.
  - `ACCESS_ERR_MEM` is driven only by timeout.

## Test plan
- LW at 0x100, ack 2 cycles after `mem_req`, rdata 0xDEADBEEF → `mem_addr`=0x100, `mem_be`=1111, `LOAD_DATA_MEM`=0xDEADBEEF, `STALL_MEM` high for 3 cycles.
- SB at 0x203, data 0x000000A5, ack immediate → `mem_addr`=0x200, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `mem_we`=1.
- LB and LBU at 0x101 with rdata 0x0000_80_00 → `LOAD_DATA_MEM`=0xFFFFFF80 and 0x00000080 respectively.
- No ack for `ACK_TIMEOUT`=15 cycles → one `ACCESS_ERR_MEM` pulse, `LOAD_DATA_MEM`=0, `STALL_MEM` drops, state returns to IDLE.
- Reset in the second REQ cycle, then ack on the next cycle → `mem_req`=0, `STALL_MEM`=0, no state change on the ack.
- With `DMEM_MISALIGN_TRAP_EN`: LH at 0x101 → no `mem_req`, `ACCESS_ERR_MEM` pulse in cycle 1, `STALL_MEM` high for 1 cycle.
